// File: rtl/mem_map_pkg.sv
// ----------------------------------------------------------------------------
// mem_map_pkg
//   System memory map shared by mem_bus, oam_dma and the cpu tests.
//   Holds the region/state enums, the region boundary constants, the CPU
//   address decoder and the OAM DMA source-page decoder.
// ----------------------------------------------------------------------------
package mem_map_pkg;

    typedef enum logic [2:0] {
        ROM,
        WRAM,
        OAM,
        HRAM,
        DMA_REG,
        NONE
    } mem_region_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_t;

    // ROM starts at 16'h0000, so only its upper limit is needed.
    localparam logic [15:0] ROM_LIMIT    = 16'h7FFF;
    // WRAM (C000-DFFF) and its echo (E000-FDFF) decode as one range.
    localparam logic [15:0] WRAM_BASE    = 16'hC000;
    localparam logic [15:0] ECHO_LIMIT   = 16'hFDFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_LIMIT    = 16'hFE9F;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;

    // CPU-side address decode.
    function automatic mem_region_t decode_addr(input logic [15:0] addr);
        mem_region_t region;
        region = NONE;
        if (addr <= ROM_LIMIT) begin
            region = ROM;
        end else if (addr >= WRAM_BASE && addr <= ECHO_LIMIT) begin
            region = WRAM;
        end else if (addr >= OAM_BASE && addr <= OAM_LIMIT) begin
            region = OAM;
        end else if (addr == DMA_REG_ADDR) begin
            region = DMA_REG;
        end else if (addr >= HRAM_BASE && addr <= HRAM_LIMIT) begin
            region = HRAM;
        end
        return region;
    endfunction

    // DMA source decode: 00-7F ROM, C0-FF WRAM (E0-FF echoes), 80-BF open bus.
    function automatic mem_region_t dma_src_region(input logic [7:0] page);
        mem_region_t region;
        region = NONE;
        if (!page[7]) begin
            region = ROM;
        end else if (page[7:6] == 2'b11) begin
            region = WRAM;
        end
        return region;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// ----------------------------------------------------------------------------
// oam_dma
//   OAM DMA engine: copies DMA_LEN bytes from page {i_page, 00} into OAM
//   starting at address 00, one byte per cycle.
//   Ports:
//     i_clk, i_rst_n    clock, async active-low reset
//     i_start, i_page   CPU write to the DMA register and its value
//     o_active          high while in START or XFER
//     o_page            last page written (DMA register read-back, resets FF)
//     o_src_addr        source address for ROM/WRAM (low 15 bits)
//     i_rom_data        ROM read data (1-cycle latency)
//     i_wram_rd_data    WRAM read data (1-cycle latency)
//     o_oam_wr_en       OAM write strobe
//     o_oam_addr        OAM write address
//     o_oam_wr_data     OAM write data
// ----------------------------------------------------------------------------
module oam_dma
    import mem_map_pkg::*;
#(
    parameter int DMA_LEN = 160
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_page,
    output logic        o_active,
    output logic [7:0]  o_page,
    output logic [14:0] o_src_addr,
    input  logic [7:0]  i_rom_data,
    input  logic [7:0]  i_wram_rd_data,
    output logic        o_oam_wr_en,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_wr_data
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN);

    dma_state_t  state;
    logic [7:0]  idx;
    logic [7:0]  src_hi;
    mem_region_t src_region_q;
    logic        active_q;
    logic        wr_q;
    logic [7:0]  oam_addr_q;

    // Write strobe and OAM address are registered one step ahead: when idx
    // advances to i+1 the byte fetched at idx i arrives and is written to i.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            src_hi       <= 8'hFF;
            src_region_q <= NONE;
            active_q     <= 1'b0;
            wr_q         <= 1'b0;
            oam_addr_q   <= '0;
        end else begin
            // Region of the fetch issued this cycle, aligned with its data.
            src_region_q <= dma_src_region(src_hi);
            if (i_start) begin
                state    <= START;
                src_hi   <= i_page;
                idx      <= '0;
                active_q <= 1'b1;
                wr_q     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        active_q <= 1'b0;
                        wr_q     <= 1'b0;
                    end
                    START: begin
                        state <= XFER;
                        idx   <= '0;
                    end
                    XFER: begin
                        if (idx == LAST_IDX) begin
                            state    <= IDLE;
                            active_q <= 1'b0;
                            wr_q     <= 1'b0;
                        end else begin
                            idx        <= idx + 8'd1;
                            oam_addr_q <= idx;
                            wr_q       <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        active_q <= 1'b0;
                        wr_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_oam_wr_data = 8'hFF;
        case (src_region_q)
            ROM:     o_oam_wr_data = i_rom_data;
            WRAM:    o_oam_wr_data = i_wram_rd_data;
            default: o_oam_wr_data = 8'hFF;
        endcase
    end

    // Bit 13 of the source (src_hi[5]) is dropped, folding E0-FF onto WRAM.
    assign o_src_addr  = {src_hi[6:0], idx};
    assign o_active    = active_q;
    assign o_page      = src_hi;
    assign o_oam_wr_en = wr_q;
    assign o_oam_addr  = oam_addr_q;

endmodule

// File: rtl/mem_bus.sv
// ----------------------------------------------------------------------------
// mem_bus
//   CPU memory bus and address decoder. Steers CPU accesses to cartridge
//   ROM, WRAM (with echo), OAM, internal HRAM or the DMA register, returns
//   read data with one-cycle latency, and arbitrates the ROM/WRAM/OAM ports
//   between the CPU and the OAM DMA engine.
//   Ports:
//     i_clk, i_rst_n                       clock, async active-low reset
//     i_cpu_rd_addr / o_cpu_rd_data        CPU read port (1-cycle latency)
//     i_cpu_wr_en/_addr/_data              CPU write port
//     o_rom_addr / i_rom_data              cartridge ROM (sync read)
//     o_wram_addr/_wr_en/_wr_data,
//     i_wram_rd_data                       work RAM (sync read)
//     o_oam_addr/_wr_en/_wr_data,
//     i_oam_rd_data                        OAM
//     o_dma_active                         OAM DMA in progress
// ----------------------------------------------------------------------------
module mem_bus
    import mem_map_pkg::*;
#(
    parameter int HRAM_DEPTH = 127,
    parameter int DMA_LEN    = 160
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_cpu_rd_addr,
    output logic [7:0]  o_cpu_rd_data,
    input  logic        i_cpu_wr_en,
    input  logic [15:0] i_cpu_wr_addr,
    input  logic [7:0]  i_cpu_wr_data,
    output logic [14:0] o_rom_addr,
    input  logic [7:0]  i_rom_data,
    output logic [12:0] o_wram_addr,
    output logic        o_wram_wr_en,
    output logic [7:0]  o_wram_wr_data,
    input  logic [7:0]  i_wram_rd_data,
    output logic [7:0]  o_oam_addr,
    output logic        o_oam_wr_en,
    output logic [7:0]  o_oam_wr_data,
    input  logic [7:0]  i_oam_rd_data,
    output logic        o_dma_active
);

    localparam int HRAM_AW = $clog2(HRAM_DEPTH);

    mem_region_t rd_region;
    mem_region_t wr_region;
    mem_region_t rd_region_q;

    logic        cpu_wram_wr;
    logic        cpu_oam_wr;
    logic        hram_wr;
    logic        dma_start;

    logic        dma_active;
    logic [7:0]  dma_page;
    logic [14:0] dma_src_addr;
    logic        dma_oam_wr;
    logic [7:0]  dma_oam_addr;
    logic [7:0]  dma_oam_data;

    logic [7:0]  hram [HRAM_DEPTH];
    logic [7:0]  hram_q;

    // While DMA runs, only HRAM and the DMA register remain CPU-visible.
    always_comb begin
        rd_region = decode_addr(i_cpu_rd_addr);
        wr_region = decode_addr(i_cpu_wr_addr);
        if (dma_active) begin
            if (rd_region != HRAM && rd_region != DMA_REG) begin
                rd_region = NONE;
            end
            if (wr_region != HRAM && wr_region != DMA_REG) begin
                wr_region = NONE;
            end
        end
    end

    assign cpu_wram_wr = i_cpu_wr_en && (wr_region == WRAM);
    assign cpu_oam_wr  = i_cpu_wr_en && (wr_region == OAM);
    assign hram_wr     = i_cpu_wr_en && (wr_region == HRAM);
    assign dma_start   = i_cpu_wr_en && (wr_region == DMA_REG);

    oam_dma #(
        .DMA_LEN (DMA_LEN)
    ) u_oam_dma (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (dma_start),
        .i_page         (i_cpu_wr_data),
        .o_active       (dma_active),
        .o_page         (dma_page),
        .o_src_addr     (dma_src_addr),
        .i_rom_data     (i_rom_data),
        .i_wram_rd_data (i_wram_rd_data),
        .o_oam_wr_en    (dma_oam_wr),
        .o_oam_addr     (dma_oam_addr),
        .o_oam_wr_data  (dma_oam_data)
    );

    // WRAM and OAM are single-address ports: a CPU write takes the address
    // for that cycle, otherwise the read address is presented.
    always_comb begin
        if (dma_active) begin
            o_rom_addr  = dma_src_addr;
            o_wram_addr = dma_src_addr[12:0];
            o_oam_addr  = dma_oam_addr;
        end else begin
            o_rom_addr  = i_cpu_rd_addr[14:0];
            o_wram_addr = cpu_wram_wr ? i_cpu_wr_addr[12:0] : i_cpu_rd_addr[12:0];
            o_oam_addr  = cpu_oam_wr  ? i_cpu_wr_addr[7:0]  : i_cpu_rd_addr[7:0];
        end
    end

    assign o_wram_wr_en   = cpu_wram_wr & i_rst_n;
    assign o_wram_wr_data = i_cpu_wr_data;
    assign o_oam_wr_en    = (dma_oam_wr | cpu_oam_wr) & i_rst_n;
    assign o_oam_wr_data  = dma_active ? dma_oam_data : i_cpu_wr_data;
    assign o_dma_active   = dma_active;

    // HRAM contents are not reset; the registered read sees pre-write data.
    always_ff @(posedge i_clk) begin
        if (hram_wr) begin
            hram[i_cpu_wr_addr[HRAM_AW-1:0]] <= i_cpu_wr_data;
        end
        hram_q <= hram[i_cpu_rd_addr[HRAM_AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_region_q <= NONE;
        end else begin
            rd_region_q <= rd_region;
        end
    end

    always_comb begin
        o_cpu_rd_data = 8'hFF;
        case (rd_region_q)
            ROM:     o_cpu_rd_data = i_rom_data;
            WRAM:    o_cpu_rd_data = i_wram_rd_data;
            OAM:     o_cpu_rd_data = i_oam_rd_data;
            HRAM:    o_cpu_rd_data = hram_q;
            DMA_REG: o_cpu_rd_data = dma_page;
            default: o_cpu_rd_data = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_mem_bus.sv
// ----------------------------------------------------------------------------
// tb_mem_bus
//   Directed bench for mem_bus with behavioural ROM, WRAM and OAM models.
// ----------------------------------------------------------------------------
module tb_mem_bus;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_cpu_rd_addr;
    logic [7:0]  o_cpu_rd_data;
    logic        i_cpu_wr_en;
    logic [15:0] i_cpu_wr_addr;
    logic [7:0]  i_cpu_wr_data;
    logic [14:0] o_rom_addr;
    logic [7:0]  i_rom_data;
    logic [12:0] o_wram_addr;
    logic        o_wram_wr_en;
    logic [7:0]  o_wram_wr_data;
    logic [7:0]  i_wram_rd_data;
    logic [7:0]  o_oam_addr;
    logic        o_oam_wr_en;
    logic [7:0]  o_oam_wr_data;
    logic [7:0]  i_oam_rd_data;
    logic        o_dma_active;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rom_mem  [32768];
    logic [7:0] wram_mem [8192];
    logic [7:0] oam_mem  [256];
    logic       mem_load;
    int         oam_wr_cnt = 0;

    always #5 i_clk = ~i_clk;

    mem_bus #(
        .HRAM_DEPTH (127),
        .DMA_LEN    (160)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_cpu_rd_addr  (i_cpu_rd_addr),
        .o_cpu_rd_data  (o_cpu_rd_data),
        .i_cpu_wr_en    (i_cpu_wr_en),
        .i_cpu_wr_addr  (i_cpu_wr_addr),
        .i_cpu_wr_data  (i_cpu_wr_data),
        .o_rom_addr     (o_rom_addr),
        .i_rom_data     (i_rom_data),
        .o_wram_addr    (o_wram_addr),
        .o_wram_wr_en   (o_wram_wr_en),
        .o_wram_wr_data (o_wram_wr_data),
        .i_wram_rd_data (i_wram_rd_data),
        .o_oam_addr     (o_oam_addr),
        .o_oam_wr_en    (o_oam_wr_en),
        .o_oam_wr_data  (o_oam_wr_data),
        .i_oam_rd_data  (i_oam_rd_data),
        .o_dma_active   (o_dma_active)
    );

    // ROM: contents fixed at time 0, synchronous read.
    initial begin
        for (int i = 0; i < 32768; i++) rom_mem[i] = 8'(i) ^ 8'h3C;
        rom_mem[15'h0150] = 8'h3C;
    end
    always @(posedge i_clk) i_rom_data <= rom_mem[o_rom_addr];

    always @(posedge i_clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8192; i++) wram_mem[i] <= 8'(i * 7 + 3);
        end else if (o_wram_wr_en) begin
            wram_mem[o_wram_addr] <= o_wram_wr_data;
        end
        i_wram_rd_data <= wram_mem[o_wram_addr];
    end

    always @(posedge i_clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) oam_mem[i] <= 8'h00;
        end else if (o_oam_wr_en) begin
            oam_mem[o_oam_addr] <= o_oam_wr_data;
            oam_wr_cnt++;
        end
        i_oam_rd_data <= oam_mem[o_oam_addr];
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        i_cpu_wr_en   = 1'b1;
        i_cpu_wr_addr = addr;
        i_cpu_wr_data = data;
    endtask

    int base_cnt;
    int bad;
    logic [7:0] exp_b;

    initial begin
        i_rst_n       = 1'b0;
        mem_load      = 1'b1;
        i_cpu_rd_addr = 16'h0150;
        cpu_write(16'hC000, 8'h77);
        repeat (3) tick();
        check("rst_rd_data", 16'(o_cpu_rd_data), 16'h00FF);
        check("rst_active", 16'(o_dma_active), 16'h0);
        check("rst_wram_we", 16'(o_wram_wr_en), 16'h0);
        check("rst_oam_we", 16'(o_oam_wr_en), 16'h0);

        // ROM read, one-cycle latency
        i_cpu_wr_en = 1'b0;
        mem_load    = 1'b0;
        i_rst_n     = 1'b1;
        #1;
        check("rom_addr", 16'(o_rom_addr), 16'h0150);
        tick();
        check("rom_rd", 16'(o_cpu_rd_data), 16'h003C);

        // WRAM write, echo read
        cpu_write(16'hC123, 8'hA5);
        i_cpu_rd_addr = 16'h0000;
        #1;
        check("wram_wr_addr", 16'(o_wram_addr), 16'h0123);
        check("wram_we", 16'(o_wram_wr_en), 16'h1);
        tick();
        i_cpu_wr_en   = 1'b0;
        i_cpu_rd_addr = 16'hE123;
        #1;
        check("echo_addr", 16'(o_wram_addr), 16'h0123);
        tick();
        check("echo_rd", 16'(o_cpu_rd_data), 16'h00A5);

        // HRAM
        cpu_write(16'hFF80, 8'h5A);
        tick();
        i_cpu_wr_en   = 1'b0;
        i_cpu_rd_addr = 16'hFF80;
        tick();
        check("hram_rd", 16'(o_cpu_rd_data), 16'h005A);
        i_cpu_rd_addr = 16'hFFFF;
        tick();
        check("ffff_rd", 16'(o_cpu_rd_data), 16'h00FF);
        cpu_write(16'hFF81, 8'h11);
        tick();
        cpu_write(16'hFF81, 8'h22);
        i_cpu_rd_addr = 16'hFF81;
        tick();
        check("hram_rbw_old", 16'(o_cpu_rd_data), 16'h0011);
        i_cpu_wr_en = 1'b0;
        tick();
        check("hram_rbw_new", 16'(o_cpu_rd_data), 16'h0022);
        i_cpu_rd_addr = 16'hFEA0;
        tick();
        check("unmapped_rd", 16'(o_cpu_rd_data), 16'h00FF);
        i_cpu_rd_addr = 16'h0000;

        // DMA from WRAM page C1
        base_cnt = oam_wr_cnt;
        cpu_write(16'hFF46, 8'hC1);
        for (int k = 1; k <= 164; k++) begin
            tick();
            i_cpu_wr_en = 1'b0;
            if (k == 1)  check("dma_active_rise", 16'(o_dma_active), 16'h1);
            if (k == 2)  check("dma_no_wr_n2", 16'(o_oam_wr_en), 16'h0);
            if (k == 3) begin
                check("dma_first_we", 16'(o_oam_wr_en), 16'h1);
                check("dma_first_addr", 16'(o_oam_addr), 16'h0000);
            end
            if (k == 10) i_cpu_rd_addr = 16'hC000;
            if (k == 11) check("dma_cpu_wram_rd", 16'(o_cpu_rd_data), 16'h00FF);
            if (k == 20) i_cpu_rd_addr = 16'hFF80;
            if (k == 21) check("dma_cpu_hram_rd", 16'(o_cpu_rd_data), 16'h005A);
            if (k == 30) i_cpu_rd_addr = 16'hFF46;
            if (k == 31) check("dma_reg_rd", 16'(o_cpu_rd_data), 16'h00C1);
            if (k == 32) i_cpu_rd_addr = 16'h0000;
            if (k == 162) begin
                check("dma_last_we", 16'(o_oam_wr_en), 16'h1);
                check("dma_last_addr", 16'(o_oam_addr), 16'h009F);
                check("dma_active_n162", 16'(o_dma_active), 16'h1);
            end
            if (k == 163) begin
                check("dma_active_fall", 16'(o_dma_active), 16'h0);
                check("dma_we_after", 16'(o_oam_wr_en), 16'h0);
            end
        end
        check("dma_wr_count", 16'(oam_wr_cnt - base_cnt), 16'd160);
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (oam_mem[i] !== wram_mem[13'h0100 + 13'(i)]) bad++;
        end
        check("dma_c1_data", 16'(bad), 16'd0);
        check("dma_c1_byte23", 16'(oam_mem[8'h23]), 16'h00A5);

        // DMA from open-bus page 80
        cpu_write(16'hFF46, 8'h80);
        for (int k = 1; k <= 165; k++) begin
            tick();
            i_cpu_wr_en = 1'b0;
        end
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (oam_mem[i] !== 8'hFF) bad++;
        end
        check("dma_80_all_ff", 16'(bad), 16'd0);

        // ROM page 00, restart at idx 50 with page 80, then reset mid-transfer
        cpu_write(16'hFF46, 8'h00);
        for (int k = 1; k <= 75; k++) begin
            tick();
            i_cpu_wr_en = 1'b0;
            if (k == 52) begin
                check("idx50_addr", 16'(o_oam_addr), 16'd49);
                cpu_write(16'hFF46, 8'h80);
            end
            if (k == 54) check("restart_start_no_we", 16'(o_oam_wr_en), 16'h0);
            if (k == 55) begin
                check("restart_we", 16'(o_oam_wr_en), 16'h1);
                check("restart_idx0", 16'(o_oam_addr), 16'h0000);
            end
            if (k == 75) begin
                i_rst_n = 1'b0;
                #1;
                check("midrst_we", 16'(o_oam_wr_en), 16'h0);
                check("midrst_active", 16'(o_dma_active), 16'h0);
                base_cnt = oam_wr_cnt;
            end
        end
        repeat (3) tick();
        i_rst_n       = 1'b1;
        i_cpu_rd_addr = 16'hFF46;
        repeat (4) tick();
        check("postrst_no_wr", 16'(oam_wr_cnt - base_cnt), 16'd0);
        check("postrst_active", 16'(o_dma_active), 16'h0);
        check("postrst_dma_reg", 16'(o_cpu_rd_data), 16'h00FF);
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (i < 20)      exp_b = 8'hFF;
            else if (i < 50) exp_b = 8'(i) ^ 8'h3C;
            else             exp_b = 8'hFF;
            if (oam_mem[i] !== exp_b) bad++;
        end
        check("restart_oam_image", 16'(bad), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus.md
# mem_bus

Memory bus and address decoder sitting directly downstream of `cpu`. It takes the CPU's read address and write strobe, decodes them against the system memory map, and steers each access to cartridge ROM, work RAM, OAM, internal high RAM, or the DMA register. It returns read data to `cpu` with one-cycle latency. It also contains the OAM DMA engine, which owns the ROM/WRAM/OAM ports while a transfer runs.

## Interface
Parameters:
- `HRAM_DEPTH`, 127: high-RAM bytes, mapped at FF80–FFFE.
- `DMA_LEN`, 160: bytes per OAM DMA transfer.

Ports:
- `i_clk` in 1: system clock; everything is rising-edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_cpu_rd_addr` in 16: CPU read address.
- `o_cpu_rd_data` out 8: read data, registered.
- `i_cpu_wr_en` in 1: CPU write strobe, one cycle per byte.
- `i_cpu_wr_addr` in 16: CPU write address.
- `i_cpu_wr_data` in 8: CPU write data.
- `o_rom_addr` out 15: ROM address; ROM is synchronous, 1-cycle read.
- `i_rom_data` in 8: ROM read data.
- `o_wram_addr` out 13: WRAM address; WRAM is synchronous, 1-cycle read.
- `o_wram_wr_en` out 1: WRAM write strobe.
- `o_wram_wr_data` out 8: WRAM write data.
- `i_wram_rd_data` in 8: WRAM read data.
- `o_oam_addr` out 8: OAM address.
- `o_oam_wr_en` out 1: OAM write strobe.
- `o_oam_wr_data` out 8: OAM write data.
- `i_oam_rd_data` in 8: OAM read data.
- `o_dma_active` out 1: high while a DMA is in START or XFER.

## Operation
Memory map:
- 0000–7FFF: ROM.
- C000–DFFF: WRAM.
- E000–FDFF: echo of WRAM; bit 13 is cleared to form the WRAM address.
- FE00–FE9F: OAM.
- FF46: DMA register.
- FF80–FFFE: HRAM.
- Everything else: reads return 8'hFF, writes are dropped.

Bus behaviour:
- Port addresses are combinational from the CPU addresses when DMA is idle.
- Writes to ROM space are dropped; ROM has no write port.
- HRAM is internal, with a synchronous read port and a write port. Contents are not reset.
- Read region is registered alongside the address. `o_cpu_rd_data` is the registered-region mux of `i_rom_data`, `i_wram_rd_data`, `i_oam_rd_data`, HRAM, the DMA register, or FF.

DMA register and engine:
- Reading FF46 returns the last value written; reset value is 8'hFF.
- DMA state machine: IDLE → START (1 cycle) → XFER (`DMA_LEN`+1 cycles) → IDLE.
- A CPU write to FF46 loads source page `src_hi` and enters START.
- In XFER, the counter `idx` runs from 0 to `DMA_LEN`.
  - Read source address {`src_hi`, `idx`}.
  - Write byte `idx`−1 to OAM address `idx`−1, pipelined at 1 byte per cycle.
- Source decode:
  - `src_hi` 00–7F: ROM.
  - C0–DF: WRAM.
  - E0–FF: WRAM with bit 5 cleared.
  - 80–BF: data is 8'hFF.

While `o_dma_active` is high:
- DMA owns the ROM, WRAM and OAM ports.
- CPU reads outside HRAM/FF46 return 8'hFF.
- CPU writes outside HRAM/FF46 are dropped.
- HRAM stays fully usable by the CPU.

## Timing
Reset values:
- `o_cpu_rd_data` = 8'hFF.
- `o_wram_wr_en` = 0 and `o_oam_wr_en` = 0, forced low during reset.
- `o_dma_active` = 0.
- DMA state = IDLE; DMA register = 8'hFF.

Read timing:
- Read latency is 1 cycle: an address presented in cycle N gives data on `o_cpu_rd_data` after the edge ending cycle N.
- Same-cycle CPU write and read to the same HRAM address returns the old data (read-before-write).

DMA timing:
- A write to FF46 in cycle N sets `o_dma_active` high from N+1.
- The first OAM write occurs in cycle N+3; the last (index 159) occurs in cycle N+162.
- `o_dma_active` drops in cycle N+163.

Boundary cases:
- A write to FF46 during DMA restarts the transfer from START with the new page; OAM bytes already written stay written.
- Reset asserted mid-DMA aborts immediately: IDLE, no further OAM writes.
- `idx` never exceeds `DMA_LEN`; no wrap.

## Structure
- `mem_map_pkg` holds:
  - the `mem_region_t` enum (ROM, WRAM, OAM, HRAM, DMA_REG, NONE);
  - region base/limit constants;
  - `DMA_REG_ADDR` = 16'hFF46;
  - the `dma_state_t` enum (IDLE, START, XFER).
- The address decode function lives in the package so that `cpu` tests can reuse it.
- Sub-module `oam_dma` contains the state machine, `idx` counter and source/OAM address generation. `mem_bus` instantiates it and handles arbitration.

## Test plan
- Reset, then read 0150 with ROM returning 8'h3C → `o_cpu_rd_data` = 8'h3C one cycle after the address; 8'hFF during reset.
- Write 8'hA5 to C123, then read E123 → `o_wram_addr` = 13'h0123 on both accesses; data 8'hA5.
- Write 8'h5A to FF80, read FF80 and FFFF → 8'h5A, then 8'hFF. Same-cycle write/read of FF81 returns the old value.
- Write 8'hC1 to FF46 → `o_dma_active` rises next cycle. OAM receives 160 writes with data from C100–C19F to addresses 00–9F; active drops at N+163. A CPU read of C000 during the transfer returns FF, a read of FF80 returns HRAM data, and FF46 reads back 8'hC1.
- Write FF46 = 8'h80 → all OAM bytes = 8'hFF. Writing FF46 again at `idx` = 50 restarts the transfer with `idx` = 0. Asserting `i_rst_n` low mid-transfer → no OAM writes after the reset edge; `o_dma_active` = 0.
